full_add: RTL and testbench
===========================

# full_add

Registered full adder: adds operand bits `a` and `b` plus carry-in `c` and presents `sum` and `carry` one clock after sampling. The width is set by a parameter. A ripple chain of 1-bit cells is built for WIDTH > 1, and the default WIDTH = 1 gives the classic single-bit full adder. It serves as the sanity-check arithmetic primitive at the leaf level of the datapath and can be instantiated wherever a registered add-with-carry is needed.

## Interface
- `WIDTH`, default 1: operand width in bits, legal range 1..64.
- `REG_OUT`, default 1: 1 registers the outputs; 0 makes the outputs combinational, and `clk`/`rst` are then unused.
- `clk` input, 1 bit: single clock, rising-edge active.
- `rst` input, 1 bit: asynchronous reset, active-high. Clears all output registers immediately on assertion.
- `a` input, WIDTH bits: operand A, unsigned.
- `b` input, WIDTH bits: operand B, unsigned.
- `c` input, 1 bit: carry-in into the LSB.
- `sum` output, WIDTH bits: (a + b + c) mod 2^WIDTH.
- `carry` output, 1 bit: carry-out of the MSB, i.e. bit WIDTH of a + b + c.

## Operation
- Combinational core:
  - {carry_n, sum_n} = a + b + c, computed as a ripple of WIDTH 1-bit cells.
  - Each cell i: s_i = a_i ^ b_i ^ ci_i and co_i = (a_i & b_i) | (ci_i & (a_i ^ b_i)).
  - ci_0 = c and ci_{i+1} = co_i. carry_n = co_{WIDTH-1}.
- Arithmetic is unsigned. There is no overflow flag beyond `carry`. The full range is legal: the max case is all-ones + all-ones + 1 = 2^(WIDTH+1) − 1, giving sum = all-ones and carry = 1.
- REG_OUT = 1: `sum`/`carry` load sum_n/carry_n on every rising `clk`. There is no enable and no hold state.
- REG_OUT = 0: `sum`/`carry` equal sum_n/carry_n directly.
- No X-propagation masking is done. Inputs are assumed driven.

## Timing
- Reset values: `sum` = 0, `carry` = 0.
  - These appear asynchronously on `rst` rising, independent of `clk`.
  - They are held while `rst` = 1.
- Latency with REG_OUT = 1:
  - Exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
  - Throughput is one result per cycle.
- Reset deassertion: the first edge after `rst` falls samples the current inputs. There is no extra dead cycle.
- Reset mid-operation: the in-flight result is discarded and the outputs go to 0. No result is replayed.
- Latency with REG_OUT = 0: zero cycles, purely combinational. The reset has no effect.
- Input changes between edges have no effect on registered outputs until the next edge.

## Structure
- Sub-module `full_add_cell`: purely combinational 1-bit adder with ports a, b, ci, s, co. It is instantiated WIDTH times in a generate loop.
- Top level `full_add`:
  - owns the carry chain wiring, the output register stage and the REG_OUT generate branch;
  - has a parameter range check (elaboration error if WIDTH < 1 or WIDTH > 64).
- No shared package is required: no typedefs, and no constants beyond the parameters.

## Test plan
- Reset: assert `rst` with a = 1, b = 1, c = 1 mid-cycle → `sum` = 0 and `carry` = 0 immediately, held until release.
- WIDTH = 1 exhaustive walk, applied in order, each checked one cycle after sampling:
  - 000 → sum 0, carry 0
  - 001 → sum 1, carry 0
  - 011 → sum 0, carry 1
  - 111 → sum 1, carry 1
  - Cover all 8 combinations.
- Latency check, WIDTH = 1: change 001 → 011 just after an edge → the output stays (1,0) until the next edge, then becomes (0,1).
- WIDTH = 4 boundaries:
  - a = 15, b = 0, c = 1 → sum 0, carry 1 (full ripple).
  - a = 15, b = 15, c = 1 → sum 15, carry 1.
  - a = 0, b = 0, c = 0 → sum 0, carry 0.
- Reset mid-stream, WIDTH = 4: drive a = 9, b = 8 on consecutive cycles and pulse `rst` between edges → the outputs are 0 during the pulse. The first post-reset edge shows the then-current inputs (9 + 8 = 17 → sum 1, carry 1).
- REG_OUT = 0, WIDTH = 8, random 1000 vectors → outputs match a + b + c with no clock, and `rst` is ignored.

Source files
------------

// File: rtl/full_add_cell.sv
// One-bit combinational full adder; the leaf of the ripple chain in full_add.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // p is the propagate term: an incoming carry passes through when exactly one operand bit is set.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_add.sv
// WIDTH-bit ripple-carry adder with carry-in and an optional output register
// that is cleared by an asynchronous reset.
module full_add #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("full_add: WIDTH must be within 1..64");
    end
  endgenerate

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  assign chain[0] = c;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_add_cell u_cell (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (chain[gi]),
        .s  (sum_next[gi]),
        .co (chain[gi+1])
      );
    end
  endgenerate

  assign carry_next = chain[WIDTH];

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] sum_reg;
      logic             carry_reg;

      // No enable: a new result is loaded on every edge once reset is released.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_reg   <= '0;
          carry_reg <= 1'b0;
        end else begin
          sum_reg   <= sum_next;
          carry_reg <= carry_next;
        end
      end

      assign sum   = sum_reg;
      assign carry = carry_reg;
    end else begin : g_comb
      // The clock and reset have no function in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign sum   = sum_next;
      assign carry = carry_next;
    end
  endgenerate

endmodule

// File: tb/tb_full_add.sv
// Bench for full_add: registered WIDTH=1 and WIDTH=4 instances plus a combinational WIDTH=8 instance,
// checked against arithmetic models and hand-computed literal values.
module tb_full_add;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_c = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;

  logic       sum1, carry1;
  logic [3:0] sum4;
  logic       carry4;
  logic [7:0] sum8;
  logic       carry8;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Expected registered outputs, written as {carry, sum}.
  logic [1:0] m1 = '0;
  logic [4:0] m4 = '0;

  always #5 clk = ~clk;

  full_add #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .sum(sum1), .carry(carry1)
  );

  full_add #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .sum(sum4), .carry(carry4)
  );

  full_add #(.WIDTH(8), .REG_OUT(1'b0)) u_w8 (
    .clk(clk), .rst(rst_c), .a(a8), .b(b8), .c(c8), .sum(sum8), .carry(carry8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the registered outputs present the sum sampled at the most recent clock edge, or zero under reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m1 = '0;
        m4 = '0;
      end else begin
        m1 = 2'(a1) + 2'(b1) + 2'(c1);
        m4 = 5'(a4) + 5'(b4) + 5'(c4);
      end
    end
  end

  // Compare process: runs on every falling edge once checking is enabled.
  initial begin
    logic [8:0] e8;
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("mdl_w1", {carry1, sum1}, m1);
        check("mdl_w4", {carry4, sum4}, m4);
        e8 = 9'(a8) + 9'(b8) + 9'(c8);
        check("mdl_w8", {carry8, sum8}, e8);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {carry, sum} for {a,b,c} = 0..7, worked out by hand.
  logic [1:0] w1_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    step();
    step();
    check("rst_hold_w1", {carry1, sum1}, 2'b00);
    check("rst_hold_w4", {carry4, sum4}, 5'd0);
    check_en = 1'b1;

    // Asynchronous reset assertion in the middle of a cycle.
    rst = 1'b0;
    a1 = 1; b1 = 1; c1 = 1;
    a4 = 4'd3; b4 = 4'd5; c4 = 1;
    step();
    check("pre_rst_w1", {carry1, sum1}, 2'b11);
    check("pre_rst_w4", {carry4, sum4}, 5'd9);
    #2 rst = 1'b1;
    #1;
    check("async_rst_w1", {carry1, sum1}, 2'b00);
    check("async_rst_w4", {carry4, sum4}, 5'd0);
    step();
    check("rst_held_w1", {carry1, sum1}, 2'b00);
    rst = 1'b0;
    step();
    check("post_rst_w1", {carry1, sum1}, 2'b11);

    // WIDTH=1 exhaustive walk.
    for (int v = 0; v < 8; v++) begin
      {a1, b1, c1} = 3'(v);
      step();
      check($sformatf("w1_walk_%0d", v), {carry1, sum1}, w1_tab[v]);
    end

    // Latency: a change between edges must not reach the registered output.
    {a1, b1, c1} = 3'b001;
    step();
    check("lat_before", {carry1, sum1}, 2'b01);
    {a1, b1, c1} = 3'b011;
    #3;
    check("lat_hold", {carry1, sum1}, 2'b01);
    step();
    check("lat_after", {carry1, sum1}, 2'b10);

    // WIDTH=4 boundaries.
    a4 = 4'd15; b4 = 4'd0; c4 = 1;
    step();
    check("w4_ripple", {carry4, sum4}, {1'b1, 4'd0});
    a4 = 4'd15; b4 = 4'd15; c4 = 1;
    step();
    check("w4_max", {carry4, sum4}, {1'b1, 4'd15});
    a4 = 4'd0; b4 = 4'd0; c4 = 0;
    step();
    check("w4_zero", {carry4, sum4}, {1'b0, 4'd0});

    // Reset pulse mid-stream: the in-flight result is dropped, then the current inputs appear.
    a4 = 4'd9; b4 = 4'd0; c4 = 0;
    step();
    check("w4_nine", {carry4, sum4}, {1'b0, 4'd9});
    b4 = 4'd8;
    #1 rst = 1'b1;
    #1;
    check("w4_rst_pulse", {carry4, sum4}, 5'd0);
    #1 rst = 1'b0;
    step();
    check("w4_post_pulse", {carry4, sum4}, {1'b1, 4'd1});

    // Random traffic on all instances; the combinational instance sees a toggling reset it must ignore.
    for (int i = 0; i < 1000; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      rst_c = 1'($urandom);
      step();
    end

    check_en = 1'b0;
    a8 = 8'd255; b8 = 8'd255; c8 = 1; rst_c = 1'b1;
    #1;
    check("w8_max_in_rst", {carry8, sum8}, {1'b1, 8'd255});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
